// File: rtl/cmn_age_matrix_tracker.sv
// cmn_age_matrix_tracker
//   Allocates entries from a pool of WIDTH slots and keeps the age matrix
//   consumed by cmn matrix arbiters: vv_matrix[i][j]=1 means entry j is valid
//   and older than entry i, so an arbiter fed this matrix grants oldest-first.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            synchronous active-high reset
//   alloc_vld      request to allocate one entry this cycle
//   alloc_rdy      a free entry is available
//   alloc_idx      lowest-numbered free entry (the one an allocation takes)
//   dealloc_vec    multi-hot set of entries to free this cycle
//   ent_vld        registered valid vector
//   vv_matrix      registered age matrix (row i = entries older than i)
//   oldest_onehot  one-hot of the oldest valid entry, 0 when empty
//   count          number of valid entries
//   full           all entries valid (registered state only)
//
// Configuration macro
//   CMN_AGE_MATRIX_ALLOC_BYPASS_EN : entries being freed this cycle count as
//   free for this cycle's allocation (adds a comb path dealloc_vec->alloc_*).
module cmn_age_matrix_tracker #(
  parameter int WIDTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alloc_vld,
  output logic                         alloc_rdy,
  output logic [$clog2(WIDTH)-1:0]     alloc_idx,
  input  logic [WIDTH-1:0]             dealloc_vec,
  output logic [WIDTH-1:0]             ent_vld,
  output logic [WIDTH-1:0][WIDTH-1:0]  vv_matrix,
  output logic [WIDTH-1:0]             oldest_onehot,
  output logic [$clog2(WIDTH+1)-1:0]   count,
  output logic                         full
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam int CNT_W = $clog2(WIDTH+1);

  logic [WIDTH-1:0]            ent_vld_q, ent_vld_d;
  logic [WIDTH-1:0][WIDTH-1:0] age_q, age_d;
  logic [WIDTH-1:0]            free;
  logic [WIDTH-1:0]            surv;
  logic [WIDTH-1:0]            alloc_oh;
  logic                        alloc_fire;
  logic [CNT_W-1:0]            count_c;

`ifdef CMN_AGE_MATRIX_ALLOC_BYPASS_EN
  assign free = ~ent_vld_q | dealloc_vec;
`else
  assign free = ~ent_vld_q;
`endif

  assign alloc_rdy = |free;

  // Lowest free index wins: scan from the top so the last hit is the lowest.
  always_comb begin
    alloc_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (free[i]) alloc_idx = IDX_W'(i);
    end
  end

  assign alloc_fire = alloc_vld && alloc_rdy;
  assign alloc_oh   = alloc_fire ? (WIDTH'(1) << alloc_idx) : '0;

  // Entries still valid after this cycle's deallocations. Dealloc bits on
  // invalid entries fall out naturally since they are already 0 here.
  assign surv = ent_vld_q & ~dealloc_vec;

  // OR-ing the allocation last makes a same-entry alloc+dealloc end valid.
  assign ent_vld_d = surv | alloc_oh;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row
    // New entry: every survivor is older (its own bit is outside surv or
    // masked by alloc_oh). Other rows: drop freed entries, drop the new
    // youngest column, and clear the whole row if this entry is being freed.
    assign age_d[gi] = alloc_oh[gi] ? (surv & ~alloc_oh)
                                    : (age_q[gi] & surv & ~alloc_oh & {WIDTH{surv[gi]}});

    // A valid entry with no older valid entry is the oldest.
    assign oldest_onehot[gi] = ent_vld_q[gi] & ~|age_q[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent_vld_q <= '0;
      age_q     <= '0;
    end else begin
      ent_vld_q <= ent_vld_d;
      age_q     <= age_d;
    end
  end

  always_comb begin
    count_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_c = count_c + CNT_W'(ent_vld_q[i]);
    end
  end

  assign count     = count_c;
  assign full      = &ent_vld_q;
  assign ent_vld   = ent_vld_q;
  assign vv_matrix = age_q;

endmodule

// File: tb/tb_cmn_age_matrix_tracker.sv
// Self-checking bench for cmn_age_matrix_tracker (WIDTH=4). The reference
// model stores a valid flag and an allocation timestamp per entry; ages,
// oldest entry and free index are derived from those timestamps.
module tb_cmn_age_matrix_tracker;

  logic              clk;
  logic              rst;
  logic              alloc_vld;
  logic              alloc_rdy;
  logic [1:0]        alloc_idx;
  logic [3:0]        dealloc_vec;
  logic [3:0]        ent_vld;
  logic [3:0][3:0]   vv_matrix;
  logic [3:0]        oldest_onehot;
  logic [2:0]        count;
  logic              full;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [3:0] m_vld;
  int         m_ts[4];
  int         m_tsc;

  // combinational outputs captured mid-cycle
  logic       obs_rdy;
  logic [1:0] obs_idx;

  cmn_age_matrix_tracker #(.WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_vld    (alloc_vld),
    .alloc_rdy    (alloc_rdy),
    .alloc_idx    (alloc_idx),
    .dealloc_vec  (dealloc_vec),
    .ent_vld      (ent_vld),
    .vv_matrix    (vv_matrix),
    .oldest_onehot(oldest_onehot),
    .count        (count),
    .full         (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One clock cycle: drive inputs, sample alloc_rdy/idx at the negedge,
  // advance the model at the posedge, return 1 time unit after the edge.
  task automatic cycle(input logic av, input logic [3:0] dv);
    logic [3:0] free;
    int         k;
    alloc_vld   = av;
    dealloc_vec = dv;
    @(negedge clk);
    obs_rdy = alloc_rdy;
    obs_idx = alloc_idx;
    @(posedge clk);
    free = ~m_vld;
`ifdef CMN_AGE_MATRIX_ALLOC_BYPASS_EN
    free = free | dv;
`endif
    k = -1;
    for (int i = 3; i >= 0; i--) if (free[i]) k = i;
    m_vld = m_vld & ~dv;
    if (av && k >= 0) begin
      m_vld[k] = 1'b1;
      m_ts[k]  = m_tsc;
      m_tsc++;
    end
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    alloc_vld   = 1'b1;
    dealloc_vec = 4'($urandom);
    repeat (2) @(posedge clk);
    #1;
    rst         = 1'b0;
    alloc_vld   = 1'b0;
    dealloc_vec = '0;
    m_vld = '0;
    m_tsc = 0;
    for (int i = 0; i < 4; i++) m_ts[i] = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ent_vld !== 4'b0) begin errors++; $display("FAIL reset_ent_vld got %b exp 0000", ent_vld); end
    checks++; if (vv_matrix !== 16'h0) begin errors++; $display("FAIL reset_vv got %h exp 0000", vv_matrix); end
    checks++; if (oldest_onehot !== 4'b0) begin errors++; $display("FAIL reset_oldest got %b exp 0000", oldest_onehot); end
    checks++; if (count !== 3'd0 || full !== 1'b0) begin errors++; $display("FAIL reset_count_full got %0d/%b exp 0/0", count, full); end
    checks++; if (alloc_rdy !== 1'b1 || alloc_idx !== 2'd0) begin errors++; $display("FAIL reset_alloc got rdy=%b idx=%0d exp 1/0", alloc_rdy, alloc_idx); end
    $display("test_reset done");
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 4'b0);
      checks++;
      if (obs_rdy !== 1'b1 || obs_idx !== 2'(k)) begin
        errors++; $display("FAIL fill_idx%0d got rdy=%b idx=%0d exp 1/%0d", k, obs_rdy, obs_idx, k);
      end
      $display("fill alloc -> idx %0d", obs_idx);
    end
    alloc_vld = 1'b0;
    checks++; if (full !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL fill_full got full=%b count=%0d exp 1/4", full, count); end
    checks++; if (vv_matrix !== 16'h7310) begin errors++; $display("FAIL fill_vv got %h exp 7310", vv_matrix); end
    checks++; if (oldest_onehot !== 4'b0001) begin errors++; $display("FAIL fill_oldest got %b exp 0001", oldest_onehot); end
  endtask

  task automatic test_dealloc_oldest();
    cycle(1'b0, 4'b0001);
    dealloc_vec = '0;
    checks++; if (ent_vld !== 4'b1110) begin errors++; $display("FAIL dealloc_vld got %b exp 1110", ent_vld); end
    checks++; if (oldest_onehot !== 4'b0010) begin errors++; $display("FAIL dealloc_oldest got %b exp 0010", oldest_onehot); end
    checks++; if (vv_matrix !== 16'h6200) begin errors++; $display("FAIL dealloc_vv got %h exp 6200", vv_matrix); end
    checks++; if (alloc_rdy !== 1'b1 || alloc_idx !== 2'd0) begin errors++; $display("FAIL dealloc_alloc got rdy=%b idx=%0d exp 1/0", alloc_rdy, alloc_idx); end
    $display("dealloc 0001 -> ent_vld %b", ent_vld);
  endtask

  task automatic test_realloc();
    cycle(1'b1, 4'b0);
    alloc_vld = 1'b0;
    checks++; if (obs_idx !== 2'd0) begin errors++; $display("FAIL realloc_idx got %0d exp 0", obs_idx); end
    checks++; if (vv_matrix !== 16'h620E) begin errors++; $display("FAIL realloc_vv got %h exp 620e", vv_matrix); end
    checks++; if (oldest_onehot !== 4'b0010) begin errors++; $display("FAIL realloc_oldest got %b exp 0010", oldest_onehot); end
    $display("realloc -> idx %0d vv %h", obs_idx, vv_matrix);
  endtask

  task automatic test_full_bypass();
    cycle(1'b1, 4'b0100);
    alloc_vld = 1'b0; dealloc_vec = '0;
`ifdef CMN_AGE_MATRIX_ALLOC_BYPASS_EN
    checks++; if (obs_rdy !== 1'b1 || obs_idx !== 2'd2) begin errors++; $display("FAIL bypass_alloc got rdy=%b idx=%0d exp 1/2", obs_rdy, obs_idx); end
    checks++; if (ent_vld !== 4'b1111) begin errors++; $display("FAIL bypass_vld got %b exp 1111", ent_vld); end
    checks++; if (vv_matrix !== 16'h2B0A) begin errors++; $display("FAIL bypass_vv got %h exp 2b0a", vv_matrix); end
`else
    checks++; if (obs_rdy !== 1'b0) begin errors++; $display("FAIL bypass_rdy got %b exp 0", obs_rdy); end
    checks++; if (ent_vld !== 4'b1011) begin errors++; $display("FAIL bypass_vld got %b exp 1011", ent_vld); end
    checks++; if (vv_matrix !== 16'h200A) begin errors++; $display("FAIL bypass_vv got %h exp 200a", vv_matrix); end
`endif
    $display("full alloc+dealloc 0100 -> ent_vld %b vv %h", ent_vld, vv_matrix);
  endtask

  task automatic test_invalid_dealloc();
    do_reset();
    cycle(1'b1, 4'b0);
    cycle(1'b1, 4'b0);
    cycle(1'b0, 4'b0001);
    cycle(1'b0, 4'b0100);
    dealloc_vec = '0;
    checks++; if (count !== 3'd1 || ent_vld !== 4'b0010) begin errors++; $display("FAIL invalid_dealloc got count=%0d vld=%b exp 1/0010", count, ent_vld); end
    checks++; if (vv_matrix !== 16'h0 || oldest_onehot !== 4'b0010) begin errors++; $display("FAIL invalid_dealloc_age got vv=%h old=%b exp 0000/0010", vv_matrix, oldest_onehot); end
    $display("dealloc of invalid entry -> count %0d", count);
  endtask

  task automatic test_random(input int n);
    logic           av, exp_rdy;
    logic [3:0]     dv, free, exp_old, grant;
    logic [1:0]     exp_idx;
    logic [3:0][3:0] exp_vv;
    int             best;
    do_reset();
    for (int c = 0; c < n; c++) begin
      av = ($urandom_range(0, 3) != 0);
      dv = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
      free = ~m_vld;
`ifdef CMN_AGE_MATRIX_ALLOC_BYPASS_EN
      free = free | dv;
`endif
      exp_rdy = |free;
      exp_idx = 2'd0;
      for (int i = 3; i >= 0; i--) if (free[i]) exp_idx = 2'(i);
      cycle(av, dv);
      checks++;
      if (obs_rdy !== exp_rdy || (exp_rdy && obs_idx !== exp_idx)) begin
        errors++; $display("FAIL rnd_alloc c=%0d got rdy=%b idx=%0d exp %b/%0d", c, obs_rdy, obs_idx, exp_rdy, exp_idx);
      end
      exp_vv  = '0;
      exp_old = '0;
      best    = -1;
      for (int i = 0; i < 4; i++) begin
        for (int j = 0; j < 4; j++)
          exp_vv[i][j] = m_vld[i] && m_vld[j] && (m_ts[j] < m_ts[i]);
        if (m_vld[i] && (best < 0 || m_ts[i] < m_ts[best])) best = i;
      end
      if (best >= 0) exp_old[best] = 1'b1;
      for (int i = 0; i < 4; i++) grant[i] = ent_vld[i] && ((ent_vld & vv_matrix[i]) == 4'b0);
      checks++;
      if (ent_vld !== m_vld || vv_matrix !== exp_vv) begin
        errors++; $display("FAIL rnd_state c=%0d got vld=%b vv=%h exp vld=%b vv=%h", c, ent_vld, vv_matrix, m_vld, exp_vv);
      end
      checks++;
      if (oldest_onehot !== exp_old || count !== 3'($countones(m_vld)) || full !== (m_vld == 4'hF)) begin
        errors++; $display("FAIL rnd_outs c=%0d got old=%b cnt=%0d full=%b exp old=%b cnt=%0d", c, oldest_onehot, count, full, exp_old, $countones(m_vld));
      end
      checks++;
      if (grant !== exp_old || $countones(oldest_onehot) > 1) begin
        errors++; $display("FAIL rnd_arbiter c=%0d got grant=%b old=%b exp %b", c, grant, oldest_onehot, exp_old);
      end
      checks++;
      if (vv_matrix[0][0] | vv_matrix[1][1] | vv_matrix[2][2] | vv_matrix[3][3]) begin
        errors++; $display("FAIL rnd_diag c=%0d got vv=%h exp diagonal 0", c, vv_matrix);
      end
      if (c % 1000 == 0) $display("random cycle %0d av=%b dv=%b vld=%b vv=%h", c, av, dv, ent_vld, vv_matrix);
    end
    alloc_vld = 1'b0; dealloc_vec = '0;
  endtask

  initial begin
    rst = 1'b1; alloc_vld = 1'b0; dealloc_vec = '0;
    test_reset();
    test_fill();
    test_dealloc_oldest();
    test_realloc();
    test_full_bypass();
    test_invalid_dealloc();
    test_random(10000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
